afu_cmd_engine: RTL and testbench

AFU_CMD_ENGINE -- requirements
Module: afu_cmd_engine

---
 rtl/afu_cmd_engine.sv | 207 ++++++++++++++++++++
 tb/tb_afu_cmd_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afu_cmd_engine.sv
// PSL command engine: allocates tags, issues commands against a credit counter, retires responses.
// Optional build macro PARITY_CHECK_EN enables checking of ha_rtagpar on incoming responses.
module afu_cmd_engine (
    input  logic        ha_pclock,
    input  logic        ha_reset,
    input  logic        req_valid,
    input  logic [12:0] req_com,
    input  logic [63:0] req_ea,
    input  logic [11:0] req_size,
    output logic        req_ready,
    input  logic        flush,
    output logic        flush_done,
    output logic        ah_cvalid,
    output logic [7:0]  ah_ctag,
    output logic        ah_ctagpar,
    output logic [12:0] ah_com,
    output logic        ah_compar,
    output logic [2:0]  ah_cabt,
    output logic [63:0] ah_cea,
    output logic        ah_ceapar,
    output logic [15:0] ah_cch,
    output logic [11:0] ah_csize,
    input  logic [7:0]  ha_croom,
    input  logic        ha_rvalid,
    input  logic [7:0]  ha_rtag,
    input  logic        ha_rtagpar,
    input  logic [7:0]  ha_response,
    input  logic [8:0]  ha_rcredits,
    output logic        done_valid,
    output logic [7:0]  done_tag,
    output logic [7:0]  done_response,
    output logic        err,
    output logic [5:0]  outstanding
);

    typedef enum logic [1:0] {StInit, StRun, StFlush} state_t;

    state_t      r_state;
    logic [31:0] r_busy;
    logic [8:0]  r_credits;
    logic        r_cvalid;
    logic [7:0]  r_ctag;
    logic        r_ctagpar;
    logic [12:0] r_com;
    logic        r_compar;
    logic [63:0] r_cea;
    logic        r_ceapar;
    logic [11:0] r_csize;
    logic        r_done_valid;
    logic [7:0]  r_done_tag;
    logic [7:0]  r_done_resp;
    logic        r_err;
    logic        r_flush_done;

    logic [4:0]  w_alloc_tag;
    logic        w_any_free;
    logic        w_accept;
    logic        w_rsp;
    logic        w_tag_busy;
    logic        w_par_ok;
    logic        w_rsp_good;
    logic        w_rsp_bad;
    logic [31:0] w_busy_d;
    logic [10:0] w_rc_ext;
    logic [10:0] w_credit_sum;
    logic        w_sat_lo;
    logic        w_sat_hi;
    logic [8:0]  w_credits_d;
    logic [5:0]  w_outstanding;

    // Lowest-numbered free tag wins; scanning downwards leaves the smallest index last.
    always_comb begin
        w_alloc_tag = 5'd0;
        w_any_free  = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_alloc_tag = 5'(i);
                w_any_free  = 1'b1;
            end
        end
    end

    always_comb begin
        w_outstanding = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_outstanding = w_outstanding + {5'd0, r_busy[i]};
        end
    end

    assign req_ready  = (r_state == StRun) && (r_credits != 9'd0) && w_any_free;
    assign w_accept   = req_valid && req_ready;
    assign w_rsp      = ha_rvalid && (r_state != StInit);
    assign w_tag_busy = (ha_rtag[7:5] == 3'b000) && r_busy[ha_rtag[4:0]];

`ifdef PARITY_CHECK_EN
    assign w_par_ok   = ^{ha_rtag, ha_rtagpar};
`else
    assign w_par_ok   = ha_rtagpar | 1'b1;
`endif

    assign w_rsp_good = w_rsp && w_tag_busy && w_par_ok;
    assign w_rsp_bad  = w_rsp && !(w_tag_busy && w_par_ok);

    // A response frees its tag in the same update that may allocate a different one.
    always_comb begin
        w_busy_d = r_busy;
        if (w_accept) begin
            w_busy_d[w_alloc_tag] = 1'b1;
        end
        if (w_rsp_good) begin
            w_busy_d[ha_rtag[4:0]] = 1'b0;
        end
    end

    // 11-bit signed sum covers -257..510 so both saturation bounds are visible.
    assign w_rc_ext     = w_rsp ? {{2{ha_rcredits[8]}}, ha_rcredits} : 11'd0;
    assign w_credit_sum = {2'b00, r_credits} + w_rc_ext - {10'd0, w_accept};
    assign w_sat_lo     = w_credit_sum[10];
    assign w_sat_hi     = !w_credit_sum[10] && (w_credit_sum[9:8] != 2'b00);

    always_comb begin
        w_credits_d = w_credit_sum[8:0];
        if (w_sat_lo) begin
            w_credits_d = 9'd0;
        end else if (w_sat_hi) begin
            w_credits_d = 9'd255;
        end
    end

    always_ff @(posedge ha_pclock) begin
        if (ha_reset) begin
            r_state      <= StInit;
            r_busy       <= 32'd0;
            r_credits    <= 9'd0;
            r_cvalid     <= 1'b0;
            r_ctag       <= 8'd0;
            r_ctagpar    <= 1'b1;
            r_com        <= 13'd0;
            r_compar     <= 1'b1;
            r_cea        <= 64'd0;
            r_ceapar     <= 1'b1;
            r_csize      <= 12'd0;
            r_done_valid <= 1'b0;
            r_done_tag   <= 8'd0;
            r_done_resp  <= 8'd0;
            r_err        <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            r_cvalid     <= w_accept;
            r_done_valid <= w_rsp_good;
            r_err        <= w_rsp_bad || ((r_state != StInit) && (w_sat_lo || w_sat_hi));
            r_busy       <= w_busy_d;
            if (w_rsp_good) begin
                r_done_tag  <= ha_rtag;
                r_done_resp <= ha_response;
            end
            if (w_accept) begin
                r_ctag    <= {3'b000, w_alloc_tag};
                r_ctagpar <= ~^w_alloc_tag;
                r_com     <= req_com;
                r_compar  <= ~^req_com;
                r_cea     <= req_ea;
                r_ceapar  <= ~^req_ea;
                r_csize   <= req_size;
            end
            case (r_state)
                StInit: begin
                    r_credits <= {1'b0, ha_croom};
                    r_state   <= StRun;
                end
                StRun: begin
                    r_credits <= w_credits_d;
                    if (flush) begin
                        r_state <= StFlush;
                    end
                end
                StFlush: begin
                    r_credits <= w_credits_d;
                    if (r_busy == 32'd0) begin
                        r_flush_done <= 1'b1;
                        r_state      <= StRun;
                    end
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign ah_cvalid     = r_cvalid;
    assign ah_ctag       = r_ctag;
    assign ah_ctagpar    = r_ctagpar;
    assign ah_com        = r_com;
    assign ah_compar     = r_compar;
    assign ah_cabt       = 3'b000;
    assign ah_cea        = r_cea;
    assign ah_ceapar     = r_ceapar;
    assign ah_cch        = 16'h0000;
    assign ah_csize      = r_csize;
    assign done_valid    = r_done_valid;
    assign done_tag      = r_done_tag;
    assign done_response = r_done_resp;
    assign err           = r_err;
    assign flush_done    = r_flush_done;
    assign outstanding   = w_outstanding;

endmodule

// File: tb/tb_afu_cmd_engine.sv
// Self-checking bench for afu_cmd_engine: directed scenarios then randomized traffic against a
// cycle-level reference model built from integer credits, a tag array and held command fields.
module tb_afu_cmd_engine;

    logic        ha_pclock = 1'b0;
    logic        ha_reset;
    logic        req_valid;
    logic [12:0] req_com;
    logic [63:0] req_ea;
    logic [11:0] req_size;
    logic        req_ready;
    logic        flush;
    logic        flush_done;
    logic        ah_cvalid;
    logic [7:0]  ah_ctag;
    logic        ah_ctagpar;
    logic [12:0] ah_com;
    logic        ah_compar;
    logic [2:0]  ah_cabt;
    logic [63:0] ah_cea;
    logic        ah_ceapar;
    logic [15:0] ah_cch;
    logic [11:0] ah_csize;
    logic [7:0]  ha_croom;
    logic        ha_rvalid;
    logic [7:0]  ha_rtag;
    logic        ha_rtagpar;
    logic [7:0]  ha_response;
    logic [8:0]  ha_rcredits;
    logic        done_valid;
    logic [7:0]  done_tag;
    logic [7:0]  done_response;
    logic        err;
    logic [5:0]  outstanding;

    always #5 ha_pclock = ~ha_pclock;

    afu_cmd_engine dut (
        .ha_pclock    (ha_pclock),
        .ha_reset     (ha_reset),
        .req_valid    (req_valid),
        .req_com      (req_com),
        .req_ea       (req_ea),
        .req_size     (req_size),
        .req_ready    (req_ready),
        .flush        (flush),
        .flush_done   (flush_done),
        .ah_cvalid    (ah_cvalid),
        .ah_ctag      (ah_ctag),
        .ah_ctagpar   (ah_ctagpar),
        .ah_com       (ah_com),
        .ah_compar    (ah_compar),
        .ah_cabt      (ah_cabt),
        .ah_cea       (ah_cea),
        .ah_ceapar    (ah_ceapar),
        .ah_cch       (ah_cch),
        .ah_csize     (ah_csize),
        .ha_croom     (ha_croom),
        .ha_rvalid    (ha_rvalid),
        .ha_rtag      (ha_rtag),
        .ha_rtagpar   (ha_rtagpar),
        .ha_response  (ha_response),
        .ha_rcredits  (ha_rcredits),
        .done_valid   (done_valid),
        .done_tag     (done_tag),
        .done_response(done_response),
        .err          (err),
        .outstanding  (outstanding)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=init, 1=run, 2=flush.
    int          m_mode;
    int          m_cred;
    bit          m_busy [32];
    logic [7:0]  m_tag;
    logic [12:0] m_com;
    logic [63:0] m_ea;
    logic [11:0] m_size;
    bit          e_cv, e_dv, e_err, e_fd;
    logic [7:0]  e_dtag, e_dresp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_par(input logic [63:0] v);
        return (($countones(v) % 2) == 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_busy[i] ? 1 : 0;
        return c;
    endfunction

    task automatic step();
        int  ltag = -1;
        int  cnt;
        int  rc;
        int  sum;
        bit  rdy, acc, rsp, good, par_ok;
        cnt = busy_count();
        for (int i = 0; i < 32; i++) if (!m_busy[i] && ltag < 0) ltag = i;
        rdy = (m_mode == 1) && (m_cred > 0) && (ltag >= 0);
        if (!ha_reset) chk("req_ready", {63'd0, req_ready}, {63'd0, rdy});
        e_cv = 0; e_dv = 0; e_err = 0; e_fd = 0;
        if (ha_reset) begin
            m_mode = 0; m_cred = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_tag = 0; m_com = 0; m_ea = 0; m_size = 0;
        end else begin
            acc = req_valid && rdy;
            rsp = ha_rvalid && (m_mode != 0);
`ifdef PARITY_CHECK_EN
            par_ok = (ha_rtagpar == odd_par({56'd0, ha_rtag}));
`else
            par_ok = 1;
`endif
            good = rsp && (ha_rtag < 8'd32) && m_busy[ha_rtag[4:0]] && par_ok;
            if (m_mode == 0) begin
                m_cred = int'(ha_croom);
                m_mode = 1;
            end else begin
                rc  = rsp ? (ha_rcredits[8] ? int'(ha_rcredits) - 512 : int'(ha_rcredits)) : 0;
                sum = m_cred + rc - (acc ? 1 : 0);
                if (sum < 0) begin sum = 0; e_err = 1; end
                else if (sum > 255) begin sum = 255; e_err = 1; end
                m_cred = sum;
                if (m_mode == 1 && flush) m_mode = 2;
                else if (m_mode == 2 && cnt == 0) begin m_mode = 1; e_fd = 1; end
            end
            if (rsp && !good) e_err = 1;
            if (acc) begin
                m_busy[ltag] = 1; m_tag = 8'(ltag);
                m_com = req_com; m_ea = req_ea; m_size = req_size; e_cv = 1;
            end
            if (good) begin
                m_busy[ha_rtag[4:0]] = 0; e_dv = 1; e_dtag = ha_rtag; e_dresp = ha_response;
            end
        end
        @(posedge ha_pclock);
        #1;
        chk("ah_cvalid", {63'd0, ah_cvalid}, {63'd0, e_cv});
        chk("done_valid", {63'd0, done_valid}, {63'd0, e_dv});
        chk("err", {63'd0, err}, {63'd0, e_err});
        chk("flush_done", {63'd0, flush_done}, {63'd0, e_fd});
        chk("outstanding", {58'd0, outstanding}, 64'(busy_count()));
        chk("ah_ctag", {56'd0, ah_ctag}, {56'd0, m_tag});
        chk("ah_com", {51'd0, ah_com}, {51'd0, m_com});
        chk("ah_cea", ah_cea, m_ea);
        chk("ah_csize", {52'd0, ah_csize}, {52'd0, m_size});
        chk("ah_ctagpar", {63'd0, ah_ctagpar}, {63'd0, odd_par({56'd0, m_tag})});
        chk("ah_compar", {63'd0, ah_compar}, {63'd0, odd_par({51'd0, m_com})});
        chk("ah_ceapar", {63'd0, ah_ceapar}, {63'd0, odd_par(m_ea)});
        chk("ah_cabt", {61'd0, ah_cabt}, 64'd0);
        chk("ah_cch", {48'd0, ah_cch}, 64'd0);
        if (e_dv) begin
            chk("done_tag", {56'd0, done_tag}, {56'd0, e_dtag});
            chk("done_response", {56'd0, done_response}, {56'd0, e_dresp});
        end
    endtask

    task automatic idle_inputs();
        req_valid = 0; flush = 0; ha_rvalid = 0; ha_rtag = 0; ha_rtagpar = 1;
        ha_response = 0; ha_rcredits = 0;
    endtask

    task automatic new_req();
        req_com  = 13'($urandom);
        req_ea   = {$urandom, $urandom};
        req_size = 12'($urandom);
    endtask

    task automatic set_rsp(input logic [7:0] tag, input int cred, input bit good_par);
        ha_rvalid   = 1;
        ha_rtag     = tag;
        ha_rtagpar  = good_par ? odd_par({56'd0, tag}) : ~odd_par({56'd0, tag});
        ha_response = 8'($urandom);
        ha_rcredits = 9'(cred);
    endtask

    task automatic do_reset(input logic [7:0] croom);
        ha_croom = croom;
        ha_reset = 1;
        step();
        step();
        ha_reset = 0;
    endtask

    initial begin
        int flush_pulses;
        int busyq[$];
        idle_inputs();
        new_req();
        ha_croom = 0;

        // Reset state, then two credits against three back-to-back requests.
        do_reset(8'd2);
        chk("rst_cvalid", {63'd0, ah_cvalid}, 64'd0);
        chk("rst_ctagpar", {63'd0, ah_ctagpar}, 64'd1);
        chk("rst_outstanding", {58'd0, outstanding}, 64'd0);
        step();
        req_valid = 1; new_req();
        step();
        chk("r029_tag0", {56'd0, ah_ctag}, 64'h00);
        new_req();
        step();
        chk("r029_tag1", {56'd0, ah_ctag}, 64'h01);
        chk("r029_cvalid2", {63'd0, ah_cvalid}, 64'd1);
        chk("r029_ready", {63'd0, req_ready}, 64'd0);
        new_req();
        step();
        chk("r029_cvalid3", {63'd0, ah_cvalid}, 64'd0);
        chk("r029_outstanding", {58'd0, outstanding}, 64'd2);

        // Retire tag 1 with one credit back; the waiting request reuses tag 1.
        set_rsp(8'h01, 1, 1);
        step();
        chk("r030_done", {63'd0, done_valid}, 64'd1);
        chk("r030_dtag", {56'd0, done_tag}, 64'h01);
        ha_rvalid = 0;
        step();
        chk("r030_reuse", {56'd0, ah_ctag}, 64'h01);
        req_valid = 0;

        // Response for a tag that was never issued still returns its credits.
        set_rsp(8'h05, 3, 1);
        step();
        chk("r031_err", {63'd0, err}, 64'd1);
        chk("r031_outstanding", {58'd0, outstanding}, 64'd2);
        chk("r031_done", {63'd0, done_valid}, 64'd0);
        ha_rvalid = 0;

        // Flush with tags 0 and 1 in flight.
        flush = 1;
        step();
        flush = 0; req_valid = 1; new_req();
        step();
        chk("r033_ready", {63'd0, req_ready}, 64'd0);
        set_rsp(8'h00, 1, 1);
        step();
        set_rsp(8'h01, 1, 1);
        step();
        ha_rvalid = 0; req_valid = 0;
        flush_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (flush_done) flush_pulses++;
        end
        chk("r033_pulses", 64'(flush_pulses), 64'd1);
        chk("r033_ready_after", {63'd0, req_ready}, 64'd1);

        // Bad tag parity on a busy tag.
        req_valid = 1; new_req();
        step();
        req_valid = 0;
        set_rsp(8'h00, 0, 0);
        step();
`ifdef PARITY_CHECK_EN
        chk("r034_err", {63'd0, err}, 64'd1);
        chk("r034_busy", {58'd0, outstanding}, 64'd1);
`else
        chk("r034_done", {63'd0, done_valid}, 64'd1);
        chk("r034_free", {58'd0, outstanding}, 64'd0);
`endif
        ha_rvalid = 0;
        step();

        // Saturation at both ends of the credit range.
        do_reset(8'd255);
        step();
        set_rsp(8'h25, 4, 1);
        step();
        chk("r032_err_hi", {63'd0, err}, 64'd1);
        ha_rvalid = 0;
        step();
        do_reset(8'd0);
        step();
        set_rsp(8'h07, -1, 1);
        step();
        chk("r032_err_lo", {63'd0, err}, 64'd1);
        ha_rvalid = 0;
        step();
        chk("r032_ready_zero", {63'd0, req_ready}, 64'd0);

        // Randomized traffic.
        do_reset(8'd8);
        for (int n = 0; n < 1500; n++) begin
            idle_inputs();
            req_valid = ($urandom_range(0, 2) != 0);
            new_req();
            flush = ($urandom_range(0, 39) == 0);
            busyq.delete();
            for (int i = 0; i < 32; i++) if (m_busy[i]) busyq.push_back(i);
            if ($urandom_range(0, 15) == 0) begin
                set_rsp(8'($urandom), int'($urandom_range(0, 3)) - 1, $urandom_range(0, 1) == 1);
            end else if (busyq.size() > 0 && $urandom_range(0, 1) == 1) begin
                set_rsp(8'(busyq[$urandom_range(0, busyq.size() - 1)]),
                        int'($urandom_range(0, 3)) - 1, $urandom_range(0, 15) != 0);
            end
            step();
        end
        idle_inputs();

        // Reset with tags in flight discards them silently.
        do_reset(8'd4);
        step();
        req_valid = 1;
        for (int i = 0; i < 3; i++) begin new_req(); step(); end
        req_valid = 0;
        chk("r027_pre", {58'd0, outstanding}, 64'd3);
        set_rsp(8'h00, 1, 1);
        ha_reset = 1;
        step();
        chk("r027_done", {63'd0, done_valid}, 64'd0);
        chk("r027_outstanding", {58'd0, outstanding}, 64'd0);
        ha_reset = 0; ha_rvalid = 0;
        step();
        chk("r027_done_after", {63'd0, done_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
